// File: rtl/router_pkg.sv
// Shared router definitions: word geometry, dispatcher state encoding and
// the destination-field decode used wherever a word is routed.
package router_pkg;

   localparam int DW       = 32;
   localparam int NPORTS   = 8;
   localparam int DEST_LSB = 29;
   localparam int DEST_W   = $clog2(NPORTS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic logic [DEST_W-1:0] dest_of(input logic [DW-1:0] word);
      return word[DEST_LSB +: DEST_W];
   endfunction

endpackage

// File: rtl/fifo_dispatch.sv
// Drain side of the router central FIFO: pops one word at a time and presents it
// on the output lane selected by its destination field, dropping it on timeout.
module fifo_dispatch
   import router_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 fifo_empty,
   input  logic [DW-1:0]        fifo_dout,
   output logic                 fifo_pop,
   output logic [NPORTS*DW-1:0] out_data,
   output logic [NPORTS-1:0]    out_valid,
   input  logic [NPORTS-1:0]    out_ready,
   output logic                 drop,
   output logic [7:0]           drop_count
);

   localparam int TIMER_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [DW-1:0]       hold_q, hold_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                drop_q, drop_d;
   logic [7:0]          drop_count_q, drop_count_d;
   logic                pop;
   logic                handshake;

   assign handshake = (state_q == SEND) && out_ready[dest_q];

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      dest_d       = dest_q;
      timer_d      = timer_q;
      drop_d       = 1'b0;
      drop_count_d = drop_count_q;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               hold_d  = fifo_dout;
               dest_d  = dest_of(fifo_dout);
               timer_d = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (handshake) begin
               // Chain straight into the next word for one word per clock.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  hold_d  = fifo_dout;
                  dest_d  = dest_of(fifo_dout);
                  timer_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
               if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                  state_d = IDLE;
                  drop_d  = 1'b1;
                  if (drop_count_q != 8'hFF) begin
                     drop_count_d = drop_count_q + 8'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_pop = resetn && pop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         dest_q       <= '0;
         timer_q      <= '0;
         drop_q       <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         dest_q       <= dest_d;
         timer_q      <= timer_d;
         drop_q       <= drop_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Lane fan-out: only the addressed lane carries valid and data, others read zero.
   for (genvar p = 0; p < NPORTS; p++) begin : g_lane
      assign out_valid[p]          = (state_q == SEND) && (dest_q == DEST_W'(p));
      assign out_data[p*DW +: DW]  = out_valid[p] ? hold_q : '0;
   end

   assign drop       = drop_q;
   assign drop_count = drop_count_q;

endmodule
